// File: rtl/locked_reg_pkg.sv
// Shared definitions for the lockable-register command front-end.
// Contents: data/timer widths, command encoding, FSM state encoding.
package locked_reg_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMER_W = 16;

    typedef enum logic [1:0] {
        CMD_WRITE     = 2'd0,
        CMD_LOCK      = 2'd1,
        CMD_DBG_ENTER = 2'd2,
        CMD_DBG_WRITE = 2'd3
    } cmd_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/debug_session_timer.sv
// Debug session timer: a 16-bit down-counter that keeps a session open.
// Ports:
//   clk_i     - clock
//   rst_ni    - synchronous active-low reset
//   load_i    - open a session and load the counter with value_i
//   value_i   - session length in cycles
//   freeze_i  - hold the counter and the session state this cycle
//   active_o  - session is open
//   expire_o  - session closes on the next edge
module debug_session_timer
    import locked_reg_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] value_i,
    input  logic               freeze_i,
    output logic               active_o,
    output logic               expire_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            cnt_d    = value_i;
            active_d = 1'b1;
        end else if (active_q && !freeze_i) begin
            // A session sits at zero for one unfrozen cycle before closing.
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;
    assign expire_o = active_q && !load_i && !freeze_i && (cnt_q == '0);

endmodule

// File: rtl/locked_reg_access_ctrl.sv
// Command front-end for the 16-bit lockable register. Accepts valid/ready
// requests, gates debug access (key, session timeout, failed-attempt lockout)
// and returns a one-cycle response with an error flag.
// Ports:
//   Clk, resetn          - clock, synchronous active-low reset
//   req_valid/req_ready  - request handshake
//   req_cmd, req_data    - command code and write data / debug key
//   rsp_valid, rsp_err   - one-cycle response strobe and error flag
//   Data_in, write, Lock - register data, normal write pulse, lock pulse
//   trusted, debug_mode  - trusted-write qualifier, debug session open
module locked_reg_access_ctrl
    import locked_reg_pkg::*;
#(
    parameter logic [DATA_W-1:0] DBG_KEY     = 16'hA5C3,
    parameter int unsigned       DBG_TIMEOUT = 64,
    parameter int unsigned       MAX_FAIL    = 3
) (
    input  logic              Clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] Data_in,
    output logic              write,
    output logic              Lock,
    output logic              trusted,
    output logic              debug_mode
);

    localparam logic [0:0]  S_IDLE = ST_IDLE;
    localparam logic [0:0]  S_EXEC = ST_EXEC;
    localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);

    logic [0:0]        state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              write_q, write_d;
    logic              lock_q, lock_d;
    logic              trusted_q, trusted_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              lock_shadow_q, lock_shadow_d;
    logic [FailW-1:0]  fail_q, fail_d;
    logic              dbg_dis_q, dbg_dis_d;

    logic accept;
    logic tmr_load;
    logic tmr_active;
    logic unused_tmr_expire;

    debug_session_timer u_timer (
        .clk_i    (Clk),
        .rst_ni   (resetn),
        .load_i   (tmr_load),
        .value_i  (TIMER_W'(DBG_TIMEOUT)),
        .freeze_i (state_q == S_EXEC),
        .active_o (tmr_active),
        .expire_o (unused_tmr_expire)
    );

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        state_d       = S_IDLE;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        write_d       = 1'b0;
        lock_d        = 1'b0;
        trusted_d     = 1'b0;
        data_d        = data_q;
        lock_shadow_d = lock_shadow_q;
        fail_d        = fail_q;
        dbg_dis_d     = dbg_dis_q;
        tmr_load      = 1'b0;

        if (accept) begin
            state_d     = S_EXEC;
            rsp_valid_d = 1'b1;
            unique case (cmd_e'(req_cmd))
                CMD_WRITE: begin
                    if (!lock_shadow_q) begin
                        data_d  = req_data;
                        write_d = 1'b1;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                CMD_LOCK: begin
                    lock_d        = 1'b1;
                    lock_shadow_d = 1'b1;
                end
                CMD_DBG_ENTER: begin
                    if (dbg_dis_q || tmr_active) begin
                        rsp_err_d = 1'b1;
                    end else if (req_data == DBG_KEY) begin
                        tmr_load = 1'b1;
                        fail_d   = '0;
                    end else begin
                        rsp_err_d = 1'b1;
                        // Reaching the limit disables debug; the count never passes it.
                        if (fail_q == FailW'(MAX_FAIL - 1)) begin
                            fail_d    = FailW'(MAX_FAIL);
                            dbg_dis_d = 1'b1;
                        end else begin
                            fail_d = fail_q + FailW'(1);
                        end
                    end
                end
                CMD_DBG_WRITE: begin
                    // Bypasses the lock: the register accepts debug_mode & trusted.
                    if (tmr_active) begin
                        data_d    = req_data;
                        trusted_d = 1'b1;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            write_q       <= 1'b0;
            lock_q        <= 1'b0;
            trusted_q     <= 1'b0;
            data_q        <= '0;
            lock_shadow_q <= 1'b0;
            fail_q        <= '0;
            dbg_dis_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            write_q       <= write_d;
            lock_q        <= lock_d;
            trusted_q     <= trusted_d;
            data_q        <= data_d;
            lock_shadow_q <= lock_shadow_d;
            fail_q        <= fail_d;
            dbg_dis_q     <= dbg_dis_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign Data_in    = data_q;
    assign write      = write_q;
    assign Lock       = lock_q;
    assign trusted    = trusted_q;
    assign debug_mode = tmr_active;

endmodule

// File: tb/tb_locked_reg_access_ctrl.sv
// Bench for locked_reg_access_ctrl: directed scenarios followed by random
// traffic, checked by a scoreboard fed from a behavioural model.
module tb_locked_reg_access_ctrl;
    import locked_reg_pkg::*;

    localparam logic [15:0] KEY     = 16'hA5C3;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned MAXF    = 3;

    logic        Clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_cmd = 2'd0;
    logic [15:0] req_data = 16'h0000;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] Data_in;
    logic        write;
    logic        Lock;
    logic        trusted;
    logic        debug_mode;

    locked_reg_access_ctrl #(
        .DBG_KEY     (KEY),
        .DBG_TIMEOUT (TIMEOUT),
        .MAX_FAIL    (MAXF)
    ) dut (
        .Clk        (Clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .Data_in    (Data_in),
        .write      (write),
        .Lock       (Lock),
        .trusted    (trusted),
        .debug_mode (debug_mode)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit err;
        bit wr;
        bit lk;
        bit tr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural state of the controller as the rules describe it.
    bit          m_init = 0;
    bit          m_busy = 0;
    bit          m_locked = 0;
    bit          m_disabled = 0;
    bit          m_open = 0;
    int          m_fails = 0;
    int          m_timer = 0;
    logic [15:0] m_data = 16'h0000;

    task automatic model_step();
        exp_t e;
        bit   was_open;
        if (!resetn) begin
            m_init = 1; m_busy = 0; m_locked = 0; m_disabled = 0; m_open = 0;
            m_fails = 0; m_timer = 0; m_data = 16'h0000;
            exp_q.delete();
        end else if (m_init) begin
            if (m_busy) begin
                m_busy = 0;
            end else begin
                was_open = m_open;
                if (m_open) begin
                    if (m_timer == 0) m_open = 0;
                    else m_timer = m_timer - 1;
                end
                if (req_valid) begin
                    m_busy = 1;
                    e = '{err: 0, wr: 0, lk: 0, tr: 0};
                    case (req_cmd)
                        2'd0: if (m_locked) e.err = 1;
                              else begin e.wr = 1; m_data = req_data; end
                        2'd1: begin e.lk = 1; m_locked = 1; end
                        2'd2: begin
                            if (m_disabled || was_open) begin
                                e.err = 1;
                            end else if (req_data == KEY) begin
                                m_open = 1; m_timer = TIMEOUT; m_fails = 0;
                            end else begin
                                e.err = 1;
                                if (m_fails < MAXF) m_fails = m_fails + 1;
                                if (m_fails >= MAXF) m_disabled = 1;
                            end
                        end
                        default: if (was_open) begin e.tr = 1; m_data = req_data; end
                                 else e.err = 1;
                    endcase
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle state checks and response scoreboard.
    initial forever begin
        exp_t e;
        @(negedge Clk);
        if (m_init) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
            chk("debug_mode", {31'd0, debug_mode}, {31'd0, m_open});
            chk("Data_in", {16'd0, Data_in}, {16'd0, m_data});
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t",
                             $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("write", {31'd0, write}, {31'd0, e.wr});
                    chk("Lock", {31'd0, Lock}, {31'd0, e.lk});
                    chk("trusted", {31'd0, trusted}, {31'd0, e.tr});
                end
            end else begin
                chk("write_idle", {31'd0, write}, 32'd0);
                chk("Lock_idle", {31'd0, Lock}, 32'd0);
                chk("trusted_idle", {31'd0, trusted}, 32'd0);
                if (exp_q.size() != 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_missing: got rsp_valid=%b expected 1 at %0t",
                             rsp_valid, $time);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [15:0] d, input bit hold);
        @(posedge Clk); #1;
        req_valid = 1'b1;
        req_cmd   = c;
        req_data  = d;
        @(posedge Clk); #1;
        // Holding valid through EXEC must not produce a second acceptance.
        if (hold) begin
            @(posedge Clk); #1;
        end
        req_valid = 1'b0;
        req_data  = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        resetn = 1'b0;
        @(posedge Clk); #1;
        resetn = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1 resetn = 1'b1;

        send(2'd0, 16'h1234, 0);
        idle(1);
        send(2'd1, 16'h0000, 0);
        send(2'd0, 16'hBEEF, 0);
        send(2'd2, KEY, 0);
        send(2'd3, 16'h0F0F, 0);
        idle(70);

        repeat (3) send(2'd2, 16'h0000, 0);
        send(2'd2, KEY, 0);
        idle(2);
        do_reset();
        send(2'd2, KEY, 0);
        // Lands the DBG_WRITE on the cycle the session timer reads 1.
        idle(63);
        send(2'd3, 16'h3C3C, 0);
        idle(5);

        send(2'd3, 16'h5555, 0);
        send(2'd0, 16'h7777, 1);

        // Reset during the EXEC cycle of a WRITE.
        @(posedge Clk); #1;
        req_valid = 1'b1; req_cmd = 2'd0; req_data = 16'hCAFE;
        @(posedge Clk); #1;
        req_valid = 1'b0; resetn = 1'b0;
        @(posedge Clk); #1;
        resetn = 1'b1;
        idle(2);

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic [1:0]  c;
            logic [15:0] d;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset();
            end else if (r < 6) begin
                idle(int'($urandom_range(30, 70)));
            end else begin
                c = 2'($urandom_range(0, 3));
                d = 16'($urandom);
                if (c == 2'd2 && $urandom_range(0, 1) == 1) d = KEY;
                send(c, d, $urandom_range(0, 3) == 0);
                idle(int'($urandom_range(0, 2)));
            end
        end

        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rsp_drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
